// File: rtl/systolic_seq_ctrl.sv
`timescale 1ns/1ps
// Sequencer for an N x N systolic MAC array: clears the cells, streams A columns and
// B rows out of the operand buffers, skews them onto the west/north edges, then freezes results.
module systolic_seq_ctrl #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int AW         = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  res_valid,
  output logic                  buf_rd_en,
  output logic [AW-1:0]         buf_addr,
  input  logic [N*DATA_WIDTH-1:0] a_col_data,
  input  logic [N*DATA_WIDTH-1:0] b_row_data,
  output logic [N*DATA_WIDTH-1:0] edge_a,
  output logic [N*DATA_WIDTH-1:0] edge_b,
  output logic                  arr_en,
  output logic                  arr_clr_n
);

  localparam int CW = $clog2(3 * N);
  localparam logic [CW-1:0] LAST_RUN = CW'(3 * N - 2);
  localparam logic [CW-1:0] NUM_RD   = CW'(N);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;

  state_t         state;
  logic [CW-1:0]  run_cnt;
  logic [CW-1:0]  run_cnt_inc;
  // vld_sr[s]: the buffer read port carried valid data s cycles ago
  logic [N-1:0]   vld_sr;

  assign run_cnt_inc = run_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      run_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_valid <= 1'b0;
      buf_rd_en <= 1'b0;
      buf_addr  <= '0;
      arr_en    <= 1'b0;
      arr_clr_n <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done      <= 1'b0;
          arr_clr_n <= 1'b1;
          if (start) begin
            state     <= CLEAR;
            busy      <= 1'b1;
            res_valid <= 1'b0;
            arr_en    <= 1'b0;
            arr_clr_n <= 1'b0;
          end
        end
        CLEAR: begin
          state     <= RUN;
          run_cnt   <= '0;
          arr_clr_n <= 1'b1;
          arr_en    <= 1'b1;
          buf_rd_en <= 1'b1;
          buf_addr  <= '0;
        end
        RUN: begin
          run_cnt   <= run_cnt_inc;
          buf_rd_en <= (run_cnt_inc < NUM_RD);
          buf_addr  <= (run_cnt_inc < NUM_RD) ? AW'(run_cnt_inc) : '0;
          // arr_en stays high after done so the frozen sums keep adding a*0
          if (run_cnt == LAST_RUN) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            res_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_sr <= '0;
    else     vld_sr <= {vld_sr[N-2:0], buf_rd_en};
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      if (gi == 0) begin : g_direct
        // lane 0 takes the buffer's registered read port directly, masked outside the burst
        assign edge_a[0 +: DATA_WIDTH] = vld_sr[0] ? a_col_data[0 +: DATA_WIDTH] : '0;
        assign edge_b[0 +: DATA_WIDTH] = vld_sr[0] ? b_row_data[0 +: DATA_WIDTH] : '0;
      end else begin : g_skew
        logic [DATA_WIDTH-1:0] a_sr [gi];
        logic [DATA_WIDTH-1:0] b_sr [gi];

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            for (int s = 0; s < gi; s++) begin
              a_sr[s] <= '0;
              b_sr[s] <= '0;
            end
          end else begin
            a_sr[0] <= a_col_data[gi*DATA_WIDTH +: DATA_WIDTH];
            b_sr[0] <= b_row_data[gi*DATA_WIDTH +: DATA_WIDTH];
            for (int s = 1; s < gi; s++) begin
              a_sr[s] <= a_sr[s-1];
              b_sr[s] <= b_sr[s-1];
            end
          end
        end

        assign edge_a[gi*DATA_WIDTH +: DATA_WIDTH] = vld_sr[gi] ? a_sr[gi-1] : '0;
        assign edge_b[gi*DATA_WIDTH +: DATA_WIDTH] = vld_sr[gi] ? b_sr[gi-1] : '0;
      end
    end
  endgenerate

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
`timescale 1ns/1ps
// Bench for systolic_seq_ctrl: operand buffers and a cell array around the sequencer,
// checked against the matrix product and the edge schedule computed from A and B.
module tb_systolic_seq_ctrl;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int AW  = 2;
  localparam int LAT = 3 * N;
  localparam int CAP = 3 * N + 24;

  logic clk, rst, start;
  logic busy, done, res_valid, buf_rd_en, arr_en, arr_clr_n;
  logic [AW-1:0] buf_addr;
  logic [N*DW-1:0] a_col_data, b_row_data, edge_a, edge_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] A [N][N];
  logic [DW-1:0] B [N][N];
  logic [DW-1:0] pa [N][N];
  logic [DW-1:0] pb [N][N];
  logic [DW-1:0] sm [N][N];
  logic [DW-1:0] sm_done [N][N];

  logic cap_busy [CAP], cap_done [CAP], cap_rv [CAP], cap_rd [CAP], cap_en [CAP], cap_clr [CAP];
  logic [AW-1:0]   cap_addr [CAP];
  logic [N*DW-1:0] cap_ea [CAP];
  logic [N*DW-1:0] cap_eb [CAP];

  systolic_seq_ctrl #(.N(N), .DATA_WIDTH(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .res_valid(res_valid),
    .buf_rd_en(buf_rd_en), .buf_addr(buf_addr), .a_col_data(a_col_data), .b_row_data(b_row_data),
    .edge_a(edge_a), .edge_b(edge_b), .arr_en(arr_en), .arr_clr_n(arr_clr_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous operand buffers: A column / B row selected by buf_addr
  always @(posedge clk) begin
    if (buf_rd_en) begin
      for (int i = 0; i < N; i++) begin
        a_col_data[i*DW +: DW] <= A[i][buf_addr];
        b_row_data[i*DW +: DW] <= B[buf_addr][i];
      end
    end
  end

  // output-stationary MAC array fed from the west/north edges
  always @(posedge clk) begin
    logic [DW-1:0] ai, bi;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ai = (j == 0) ? edge_a[i*DW +: DW] : pa[i][j-1];
        bi = (i == 0) ? edge_b[j*DW +: DW] : pb[i-1][j];
        if (!arr_clr_n || !arr_en) begin
          pa[i][j] <= '0;
          pb[i][j] <= '0;
          sm[i][j] <= '0;
        end else begin
          pa[i][j] <= ai;
          pb[i][j] <= bi;
          sm[i][j] <= sm[i][j] + ai * bi;
        end
      end
    end
  end

  function automatic logic [DW-1:0] ref_c(int i, int j);
    int s = 0;
    for (int k = 0; k < N; k++) s += int'(A[i][k]) * int'(B[k][j]);
    return DW'(s % 256);
  endfunction

  function automatic logic [N*DW-1:0] exp_edge_a(int t);
    logic [N*DW-1:0] v = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < N) v[i*DW +: DW] = A[i][t-i];
    return v;
  endfunction

  function automatic logic [N*DW-1:0] exp_edge_b(int t);
    logic [N*DW-1:0] v = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < N) v[j*DW +: DW] = B[t-j][j];
    return v;
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        case (mode)
          0: begin A[i][j] = (i == j) ? 8'd1 : 8'd0; B[i][j] = DW'(4 * i + j + 1); end
          1: begin A[i][j] = 8'd1; B[i][j] = 8'd1; end
          2: begin A[i][j] = 8'd16; B[i][j] = 8'd16; end
          3: begin A[i][j] = (i == j) ? 8'd1 : 8'd0; B[i][j] = DW'($urandom_range(0, 255)); end
          default: begin A[i][j] = DW'($urandom_range(0, 255)); B[i][j] = DW'($urandom_range(0, 255)); end
        endcase
      end
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
  endtask

  // cycle c=0 is the cycle right after start is sampled; start is held for 'hold' samples
  task automatic capture(input int n, input int hold);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (c >= hold - 1) start = 1'b0;
      cap_busy[c] = busy; cap_done[c] = done; cap_rv[c] = res_valid; cap_rd[c] = buf_rd_en;
      cap_en[c] = arr_en; cap_clr[c] = arr_clr_n; cap_addr[c] = buf_addr;
      cap_ea[c] = edge_a; cap_eb[c] = edge_b;
      if (c == LAT) sm_done = sm;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    a_col_data = '0; b_row_data = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, res_valid, buf_rd_en, arr_en, arr_clr_n, buf_addr, edge_a, edge_b} !== '0) begin
      n_bad++;
      $display("FAIL reset_hold: got busy=%b done=%b rv=%b rd=%b en=%b clr_n=%b addr=%0d ea=%h eb=%h want all 0",
               busy, done, res_valid, buf_rd_en, arr_en, arr_clr_n, buf_addr, edge_a, edge_b);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, res_valid, buf_rd_en, arr_en, arr_clr_n} !== 6'b000001) begin
      n_bad++;
      $display("FAIL reset_release: got busy=%b done=%b rv=%b rd=%b en=%b clr_n=%b want 000001",
               busy, done, res_valid, buf_rd_en, arr_en, arr_clr_n);
    end
    $display("test_reset done");
  endtask

  task automatic check_sums(input string tag, input logic use_snapshot);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        logic [DW-1:0] got;
        got = use_snapshot ? sm_done[i][j] : sm[i][j];
        n_cmp++;
        if (got !== ref_c(i, j)) begin
          n_bad++;
          $display("FAIL %s cell(%0d,%0d): got %0d want %0d", tag, i, j, got, ref_c(i, j));
        end
      end
  endtask

  task automatic test_identity();
    int first_done, n_done, rv_low;
    fill(0);
    launch();
    capture(LAT + 21, 1);
    first_done = -1; n_done = 0; rv_low = 0;
    for (int c = 0; c < LAT + 21; c++) begin
      if (cap_done[c]) begin n_done++; if (first_done < 0) first_done = c; end
      if (c >= LAT && (!cap_rv[c] || !cap_en[c])) rv_low++;
    end
    n_cmp++;
    if (first_done != LAT || n_done != 1) begin
      n_bad++;
      $display("FAIL identity_latency: got first done c=%0d count %0d want c=%0d count 1", first_done, n_done, LAT);
    end
    n_cmp++;
    if (rv_low != 0) begin
      n_bad++;
      $display("FAIL identity_hold: got %0d cycles with res_valid/arr_en low after done want 0", rv_low);
    end
    check_sums("identity_done", 1'b1);
    check_sums("identity_after20", 1'b0);
    $display("test_identity done");
  endtask

  task automatic test_ones();
    int bad_a3, bad_b2;
    fill(1);
    launch();
    capture(LAT + 2, 1);
    bad_a3 = 0; bad_b2 = 0;
    for (int c = 0; c < LAT + 2; c++) begin
      logic [N*DW-1:0] ea, eb;
      int t;
      t = c - 2; ea = cap_ea[c]; eb = cap_eb[c];
      if ((ea[3*DW +: DW] != 0) != (t >= 3 && t <= 6)) bad_a3++;
      if ((eb[2*DW +: DW] != 0) != (t >= 2 && t <= 5)) bad_b2++;
    end
    n_cmp++;
    if (bad_a3 != 0) begin
      n_bad++;
      $display("FAIL ones_edge_a3: got %0d cycles off-window want 0", bad_a3);
    end
    n_cmp++;
    if (bad_b2 != 0) begin
      n_bad++;
      $display("FAIL ones_edge_b2: got %0d cycles off-window want 0", bad_b2);
    end
    check_sums("ones", 1'b1);
    $display("test_ones done");
  endtask

  task automatic test_wrap();
    int clr_low, clr_at;
    fill(2);
    launch();
    capture(LAT + 2, 1);
    clr_low = 0; clr_at = -1;
    for (int c = 0; c < LAT + 2; c++)
      if (!cap_clr[c]) begin clr_low++; clr_at = c; end
    n_cmp++;
    if (clr_low != 1 || clr_at != 0) begin
      n_bad++;
      $display("FAIL wrap_clear: got %0d low cycles last at c=%0d want 1 at c=0", clr_low, clr_at);
    end
    check_sums("wrap", 1'b1);
    $display("test_wrap done");
  endtask

  task automatic test_start_held();
    int n_done, n_rd, addr_bad, exp_addr;
    fill(4);
    launch();
    capture(LAT + 6, 8);
    n_done = 0; n_rd = 0; addr_bad = 0; exp_addr = 0;
    for (int c = 0; c < LAT + 6; c++) begin
      if (cap_done[c]) n_done++;
      if (cap_rd[c]) begin
        if (int'(cap_addr[c]) != exp_addr) addr_bad++;
        exp_addr++; n_rd++;
      end
    end
    n_cmp++;
    if (n_done != 1 || n_rd != N || addr_bad != 0) begin
      n_bad++;
      $display("FAIL start_held: got done=%0d reads=%0d bad_addr=%0d want 1 %0d 0", n_done, n_rd, addr_bad, N);
    end
    check_sums("start_held", 1'b1);
    $display("test_start_held done");
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      fill(4);
      launch();
      capture(LAT + 2, 1);
      for (int c = 0; c < LAT + 2; c++) begin
        int t;
        logic [5:0] got_f, exp_f;
        logic exp_rd;
        t = c - 2;
        exp_rd = (c >= 1 && c <= N);
        exp_f = {c < LAT, c == LAT, c >= LAT, c >= 1, c != 0, exp_rd};
        got_f = {cap_busy[c], cap_done[c], cap_rv[c], cap_en[c], cap_clr[c], cap_rd[c]};
        n_cmp++;
        if (got_f !== exp_f) begin
          n_bad++;
          $display("FAIL sched_ctrl it=%0d c=%0d: got busy/done/rv/en/clr/rd=%b want %b", it, c, got_f, exp_f);
        end
        if (exp_rd) begin
          n_cmp++;
          if (int'(cap_addr[c]) != c - 1) begin
            n_bad++;
            $display("FAIL sched_addr it=%0d c=%0d: got %0d want %0d", it, c, cap_addr[c], c - 1);
          end
        end
        n_cmp++;
        if (cap_ea[c] !== exp_edge_a(t) || cap_eb[c] !== exp_edge_b(t)) begin
          n_bad++;
          $display("FAIL sched_edge it=%0d t=%0d: got a=%h b=%h want a=%h b=%h",
                   it, t, cap_ea[c], cap_eb[c], exp_edge_a(t), exp_edge_b(t));
        end
      end
      check_sums("random", 1'b1);
      $display("test_random iteration %0d done", it);
    end
  endtask

  task automatic test_reset_mid_run();
    int n_done;
    fill(4);
    launch();
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, res_valid, buf_rd_en, arr_en, arr_clr_n, buf_addr, edge_a, edge_b} !== '0) begin
      n_bad++;
      $display("FAIL midrun_reset: got busy=%b done=%b rv=%b rd=%b en=%b clr_n=%b addr=%0d ea=%h eb=%h want all 0",
               busy, done, res_valid, buf_rd_en, arr_en, arr_clr_n, buf_addr, edge_a, edge_b);
    end
    n_done = 0;
    repeat (2) begin @(negedge clk); if (done) n_done++; end
    rst = 1'b0;
    repeat (LAT + 3) begin @(negedge clk); if (done || busy) n_done++; end
    n_cmp++;
    if (n_done != 0) begin
      n_bad++;
      $display("FAIL midrun_no_done: got %0d cycles with done/busy want 0", n_done);
    end
    fill(3);
    launch();
    capture(LAT + 1, 1);
    n_cmp++;
    if (cap_done[LAT] !== 1'b1) begin
      n_bad++;
      $display("FAIL midrun_restart_done: got %b want 1", cap_done[LAT]);
    end
    check_sums("midrun_restart", 1'b1);
    $display("test_reset_mid_run done");
  endtask

  task automatic test_back_to_back();
    int first_done;
    fill(4);
    launch();
    capture(LAT + 1, 1);
    check_sums("b2b_first", 1'b1);
    start = 1'b1;
    fill(4);
    capture(LAT + 1, 1);
    n_cmp++;
    if (cap_rv[0] !== 1'b0 || cap_clr[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_accept: got rv=%b clr_n=%b want 0 0", cap_rv[0], cap_clr[0]);
    end
    first_done = -1;
    for (int c = 0; c < LAT + 1; c++) if (cap_done[c] && first_done < 0) first_done = c;
    n_cmp++;
    if (first_done != LAT) begin
      n_bad++;
      $display("FAIL b2b_latency: got done at c=%0d want %0d", first_done, LAT);
    end
    check_sums("b2b_second", 1'b1);
    $display("test_back_to_back done");
  endtask

  initial begin
    test_reset();
    test_identity();
    test_ones();
    test_wrap();
    test_start_held();
    test_random();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
